alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle integer ALU between two requesters: port 0 (execute stage) and port 1 (branch/coprocessor side-path). Each port gets a valid/ready request channel and a valid/ready response channel. Grants are round-robin, the ALU is driven combinationally during the grant cycle, and the result plus flags are captured in one response register. Sits directly in front of the ALU in the core datapath.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request present (N = 0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_op  in  OPCODE_LENGTH  ALU operation
- reqN_a, reqN_b  in  DATA_WIDTH  operands
- rspN_valid  out  1  response present for port N
- rspN_ready  in  1  port N consumes response
- rspN_result  out  DATA_WIDTH  captured ALUResult
- rspN_blt, rspN_bgt, rspN_zero  out  1  captured Con_BLT/Con_BGT/zero
- rspN_err  out  1  request opcode was undefined
- alu_srca, alu_srcb  out  DATA_WIDTH  to ALU SrcA/SrcB
- alu_op  out  OPCODE_LENGTH  to ALU Operation
- alu_result  in  DATA_WIDTH  from ALU
- alu_blt, alu_bgt, alu_zero  in  1  from ALU flags

## Operation
- Response register states: EMPTY (no valid response) and FULL (owner = 0 or 1).
- can_accept = EMPTY, or FULL with rsp_owner_ready asserted in the same cycle. This gives pass-through, so a new request can be accepted in the cycle the old response drains.
- Grant, combinational:
  - Only one reqN_valid: that port wins.
  - Both valid: the port not granted last wins.
  - last_grant updates only on an accepted handshake.
- reqN_ready = can_accept & grant==N. At most one ready is high per cycle. Ready does not depend on reqN_valid of the same port beyond the grant logic.
- ALU drive:
  - When a grant is active, alu_srca/alu_srcb/alu_op = granted port's a/b/op.
  - Otherwise all zero (op 4'b0000).
- Capture on accept: result/flags from the ALU inputs. err = 1 if op is not in {0000,0001,0010,0011,0100,0101,0110,0111,1000,1010,1100}. Undefined ops are still passed to the ALU and the result is captured as returned (expected 0). Owner = granted port.
- rspN_valid = FULL & owner==N. rspN_result/flags/err are driven from the shared register on both ports. Their value is only meaningful while rspN_valid is high.
- Drain without new accept: FULL → EMPTY.
- rspN_ready while rspN_valid is low is ignored.
- Requester rules: must hold op/a/b stable while valid & !ready. Must not drop valid before the handshake.

## Timing
- Reset values:
  - All rsp outputs 0, state EMPTY.
  - last_grant = 1, so port 0 wins the first contention.
  - alu_* outputs 0 and reqN_ready 0 during reset.
- Latency: request accepted at edge k → rspN_valid high from cycle k+1.
- Throughput: one operation per cycle when the owner holds rsp_ready high.
- Response hold: stays valid with stable data until rsp_ready is sampled high.
- Simultaneous drain + accept: register reloads, valid stays high, owner may switch ports in the same cycle.
- Reset mid-operation: a pending response is discarded and not replayed. Requesters re-issue after reset.
- No combinational path from rspN_ready to rspN_valid. A path from rspN_ready to reqN_ready is permitted.

## Test plan
- Single request, port 0: ADD (op 0010) a=5, b=7. ready high in cycle 0; rsp0_valid in cycle 1 with result 12, flags 0, err 0; rsp1_valid stays 0.
- Contention: both ports valid from reset, port 0 ADD 1+1 and port 1 SUB (op 0110) 3−5, rsp ready held 1.
  - Grants go port 0 then port 1.
  - rsp0 result 2.
  - rsp1 result 0xFFFFFFFE with blt=1, bgt=0, zero=0.
  - Then they alternate while both stay valid.
- Backpressure: rsp0_ready=0 for 3 cycles after a response. rsp0_valid and data are held, both reqN_ready stay 0, and there is no ALU drive. Raising ready accepts the waiting request in that same cycle.
- Back-to-back: port 1 streams 4 XOR (op 0011) ops with rsp1_ready=1. There are 4 consecutive accepts and 4 consecutive responses with no bubble. Example: a=0xF0F0_F0F0, b=0xFFFF_0000 → 0x0F0F_F0F0.
- Undefined opcode 1111 on port 0: response has err=1, result 0, flags 0.
- Reset asserted while FULL (owner 1): the next cycle has rsp1_valid=0, and port 0 wins the first contention after reset.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signals of the two-port ALU arbiter.
// slave = arbiter side; master = requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [OPCODE_LENGTH-1:0] req0_op;
  logic [DATA_WIDTH-1:0]    req0_a;
  logic [DATA_WIDTH-1:0]    req0_b;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [OPCODE_LENGTH-1:0] req1_op;
  logic [DATA_WIDTH-1:0]    req1_a;
  logic [DATA_WIDTH-1:0]    req1_b;

  logic                     rsp0_valid;
  logic                     rsp0_ready;
  logic [DATA_WIDTH-1:0]    rsp0_result;
  logic                     rsp0_blt;
  logic                     rsp0_bgt;
  logic                     rsp0_zero;
  logic                     rsp0_err;

  logic                     rsp1_valid;
  logic                     rsp1_ready;
  logic [DATA_WIDTH-1:0]    rsp1_result;
  logic                     rsp1_blt;
  logic                     rsp1_bgt;
  logic                     rsp1_zero;
  logic                     rsp1_err;

  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_blt;
  logic                     alu_bgt;
  logic                     alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_blt,
    output rsp0_bgt, rsp0_zero, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_blt,
    output rsp1_bgt, rsp1_zero, rsp1_err,
    input  rsp1_ready,
    output alu_srca, alu_srcb, alu_op,
    input  alu_result, alu_blt, alu_bgt, alu_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_blt,
    input  rsp0_bgt, rsp0_zero, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_blt,
    input  rsp1_bgt, rsp1_zero, rsp1_err,
    output rsp1_ready,
    input  alu_srca, alu_srcb, alu_op,
    output alu_result, alu_blt, alu_bgt, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the single-cycle ALU between two requesters,
// with one response register that can drain and reload in the same cycle.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;
  logic                     blt_q, blt_d;
  logic                     bgt_q, bgt_d;
  logic                     zero_q, zero_d;
  logic                     err_q, err_d;

  logic                     own_rdy;
  logic                     can_accept;
  logic                     any_req;
  logic                     gnt;
  logic                     accept;
  logic [OPCODE_LENGTH-1:0] sel_op;
  logic [DATA_WIDTH-1:0]    sel_a;
  logic [DATA_WIDTH-1:0]    sel_b;

  function automatic logic op_undef(
    input logic [OPCODE_LENGTH-1:0] op
  );
    logic u;
    u = 1'b1;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1010, 4'b1100: u = 1'b0;
      default:                   u = 1'b1;
    endcase
    return u;
  endfunction

  always_comb begin
    own_rdy    = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    can_accept = (state_q == EMPTY) | own_rdy;
    any_req    = bus.req0_valid | bus.req1_valid;
    // Contention goes to the port that lost last time
    if (bus.req0_valid && bus.req1_valid) begin
      gnt = ~last_q;
    end else begin
      gnt = bus.req1_valid;
    end
    accept = ~reset & any_req & can_accept;
    sel_op = gnt ? bus.req1_op : bus.req0_op;
    sel_a  = gnt ? bus.req1_a : bus.req0_a;
    sel_b  = gnt ? bus.req1_b : bus.req0_b;
  end

  always_comb begin
    bus.req0_ready = accept & ~gnt;
    bus.req1_ready = accept & gnt;
    bus.alu_srca   = '0;
    bus.alu_srcb   = '0;
    bus.alu_op     = '0;
    if (accept) begin
      bus.alu_srca = sel_a;
      bus.alu_srcb = sel_b;
      bus.alu_op   = sel_op;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    blt_d    = blt_q;
    bgt_d    = bgt_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = FULL;
      owner_d  = gnt;
      last_d   = gnt;
      result_d = bus.alu_result;
      blt_d    = bus.alu_blt;
      bgt_d    = bus.alu_bgt;
      zero_d   = bus.alu_zero;
      err_d    = op_undef(sel_op);
    end else if (state_q == FULL && own_rdy) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      blt_q    <= 1'b0;
      bgt_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
      blt_q    <= blt_d;
      bgt_q    <= bgt_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.rsp0_valid  = (state_q == FULL) & ~owner_q;
    bus.rsp1_valid  = (state_q == FULL) & owner_q;
    bus.rsp0_result = result_q;
    bus.rsp1_result = result_q;
    bus.rsp0_blt    = blt_q;
    bus.rsp1_blt    = blt_q;
    bus.rsp0_bgt    = bgt_q;
    bus.rsp1_bgt    = bgt_q;
    bus.rsp0_zero   = zero_q;
    bus.rsp1_zero   = zero_q;
    bus.rsp0_err    = err_q;
    bus.rsp1_err    = err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU
// standing in for the real datapath ALU.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_arbiter_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) intf ();

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch compare flags come only from SUB
  always_comb begin
    intf.alu_result = 32'h0;
    intf.alu_blt    = 1'b0;
    intf.alu_bgt    = 1'b0;
    intf.alu_zero   = 1'b0;
    case (intf.alu_op)
      4'b0010: intf.alu_result = intf.alu_srca + intf.alu_srcb;
      4'b0011: intf.alu_result = intf.alu_srca ^ intf.alu_srcb;
      4'b0110: begin
        intf.alu_result = intf.alu_srca - intf.alu_srcb;
        intf.alu_blt = $signed(intf.alu_srca) < $signed(intf.alu_srcb);
        intf.alu_bgt = $signed(intf.alu_srca) > $signed(intf.alu_srcb);
        intf.alu_zero = intf.alu_srca == intf.alu_srcb;
      end
      4'b1010: intf.alu_result = intf.alu_srca << intf.alu_srcb[4:0];
      4'b1100: intf.alu_result = intf.alu_srca >> intf.alu_srcb[4:0];
      default: intf.alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [31:0] xa   [4];
  logic [31:0] xb   [4];
  logic [31:0] xexp [4];
  logic [3:0]  uop  [5];
  logic        uerr [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    xa[0] = 32'hF0F0_F0F0; xb[0] = 32'hFFFF_0000; xexp[0] = 32'h0F0F_F0F0;
    xa[1] = 32'h0000_0000; xb[1] = 32'h0000_0000; xexp[1] = 32'h0000_0000;
    xa[2] = 32'h1234_5678; xb[2] = 32'hFFFF_FFFF; xexp[2] = 32'hEDCB_A987;
    xa[3] = 32'hAAAA_AAAA; xb[3] = 32'h5555_5555; xexp[3] = 32'hFFFF_FFFF;
    uop[0] = 4'b1111; uerr[0] = 1'b1;
    uop[1] = 4'b1001; uerr[1] = 1'b1;
    uop[2] = 4'b1010; uerr[2] = 1'b0;
    uop[3] = 4'b1100; uerr[3] = 1'b0;
    uop[4] = 4'b1101; uerr[4] = 1'b1;

    reset = 1'b1;
    intf.req0_valid = 1'b1; intf.req0_op = 4'b0010;
    intf.req0_a = 32'd5;    intf.req0_b = 32'd7;
    intf.req1_valid = 1'b0; intf.req1_op = 4'b0000;
    intf.req1_a = 32'd0;    intf.req1_b = 32'd0;
    intf.rsp0_ready = 1'b1;
    intf.rsp1_ready = 1'b1;

    // reset state
    @(negedge clk); #1;
    chk1("rst_req0_ready", intf.req0_ready, 1'b0);
    chk1("rst_req1_ready", intf.req1_ready, 1'b0);
    chk("rst_alu_op", {28'd0, intf.alu_op}, 32'h0);
    chk("rst_alu_srca", intf.alu_srca, 32'h0);
    chk1("rst_rsp0_valid", intf.rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", intf.rsp1_valid, 1'b0);
    chk("rst_rsp0_result", intf.rsp0_result, 32'h0);

    // single request on port 0
    @(negedge clk); reset = 1'b0; #1;
    chk1("single_req0_ready", intf.req0_ready, 1'b1);
    chk1("single_req1_ready", intf.req1_ready, 1'b0);
    chk("single_alu_srca", intf.alu_srca, 32'd5);
    chk("single_alu_srcb", intf.alu_srcb, 32'd7);
    chk("single_alu_op", {28'd0, intf.alu_op}, 32'h2);
    @(negedge clk); intf.req0_valid = 1'b0; #1;
    chk1("single_rsp0_valid", intf.rsp0_valid, 1'b1);
    chk1("single_rsp1_valid", intf.rsp1_valid, 1'b0);
    chk("single_result", intf.rsp0_result, 32'd12);
    chk("single_flags", {29'd0, intf.rsp0_blt, intf.rsp0_bgt,
        intf.rsp0_zero}, 32'h0);
    chk1("single_err", intf.rsp0_err, 1'b0);
    chk("single_idle_alu_op", {28'd0, intf.alu_op}, 32'h0);
    @(negedge clk); #1;
    chk1("single_drained", intf.rsp0_valid, 1'b0);

    // contention from reset
    reset = 1'b1;
    intf.req0_valid = 1'b1; intf.req0_op = 4'b0010;
    intf.req0_a = 32'd1;    intf.req0_b = 32'd1;
    intf.req1_valid = 1'b1; intf.req1_op = 4'b0110;
    intf.req1_a = 32'd3;    intf.req1_b = 32'd5;
    @(negedge clk); reset = 1'b0; #1;
    chk1("cont0_req0_ready", intf.req0_ready, 1'b1);
    chk1("cont0_req1_ready", intf.req1_ready, 1'b0);
    @(negedge clk); #1;
    chk1("cont1_rsp0_valid", intf.rsp0_valid, 1'b1);
    chk("cont1_rsp0_result", intf.rsp0_result, 32'd2);
    chk1("cont1_req1_ready", intf.req1_ready, 1'b1);
    chk1("cont1_req0_ready", intf.req0_ready, 1'b0);
    chk("cont1_alu_srca", intf.alu_srca, 32'd3);
    @(negedge clk); #1;
    chk1("cont2_rsp1_valid", intf.rsp1_valid, 1'b1);
    chk1("cont2_rsp0_valid", intf.rsp0_valid, 1'b0);
    chk("cont2_rsp1_result", intf.rsp1_result, 32'hFFFF_FFFE);
    chk("cont2_rsp1_flags", {29'd0, intf.rsp1_blt, intf.rsp1_bgt,
        intf.rsp1_zero}, 32'h4);
    chk1("cont2_req0_ready", intf.req0_ready, 1'b1);

    // backpressure on port 0's response
    @(negedge clk); intf.rsp0_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk1("bp_rsp0_valid", intf.rsp0_valid, 1'b1);
      chk("bp_rsp0_result", intf.rsp0_result, 32'd2);
      chk1("bp_req0_ready", intf.req0_ready, 1'b0);
      chk1("bp_req1_ready", intf.req1_ready, 1'b0);
      chk("bp_alu_op", {28'd0, intf.alu_op}, 32'h0);
      chk("bp_alu_srca", intf.alu_srca, 32'h0);
      @(negedge clk); #1;
    end
    intf.rsp0_ready = 1'b1; #1;
    chk1("bp_rel_req1_ready", intf.req1_ready, 1'b1);
    chk1("bp_rel_req0_ready", intf.req0_ready, 1'b0);
    chk("bp_rel_alu_op", {28'd0, intf.alu_op}, 32'h6);
    @(negedge clk); intf.req0_valid = 1'b0; intf.req1_valid = 1'b0; #1;
    chk1("bp_rsp1_valid", intf.rsp1_valid, 1'b1);
    chk1("bp_rsp0_valid_lo", intf.rsp0_valid, 1'b0);
    chk("bp_rsp1_result", intf.rsp1_result, 32'hFFFF_FFFE);
    @(negedge clk); #1;
    chk1("bp_drained", intf.rsp1_valid, 1'b0);

    // back-to-back XOR on port 1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      intf.req1_valid = 1'b1; intf.req1_op = 4'b0011;
      intf.req1_a = xa[i];    intf.req1_b = xb[i];
      #1;
      chk1("b2b_req1_ready", intf.req1_ready, 1'b1);
      if (i > 0) begin
        chk1("b2b_rsp1_valid", intf.rsp1_valid, 1'b1);
        chk("b2b_rsp1_result", intf.rsp1_result, xexp[i-1]);
      end
    end
    @(negedge clk); intf.req1_valid = 1'b0; #1;
    chk1("b2b_last_valid", intf.rsp1_valid, 1'b1);
    chk("b2b_last_result", intf.rsp1_result, xexp[3]);
    @(negedge clk); #1;
    chk1("b2b_drained", intf.rsp1_valid, 1'b0);

    // opcode decode for err
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      intf.req0_valid = 1'b1; intf.req0_op = uop[i];
      intf.req0_a = 32'd9;    intf.req0_b = 32'd3;
      #1;
      chk1("op_req0_ready", intf.req0_ready, 1'b1);
      chk("op_alu_op", {28'd0, intf.alu_op}, {28'd0, uop[i]});
      @(negedge clk); intf.req0_valid = 1'b0; #1;
      chk1("op_rsp0_valid", intf.rsp0_valid, 1'b1);
      chk1("op_rsp0_err", intf.rsp0_err, uerr[i]);
      if (uerr[i]) begin
        chk("op_undef_result", intf.rsp0_result, 32'h0);
        chk("op_undef_flags", {29'd0, intf.rsp0_blt, intf.rsp0_bgt,
            intf.rsp0_zero}, 32'h0);
      end
    end

    // reset while FULL with owner 1
    @(negedge clk);
    intf.rsp1_ready = 1'b0;
    intf.req1_valid = 1'b1; intf.req1_op = 4'b0010;
    intf.req1_a = 32'd1;    intf.req1_b = 32'd2;
    #1;
    chk1("rf_req1_ready", intf.req1_ready, 1'b1);
    @(negedge clk); intf.req1_valid = 1'b0; #1;
    chk1("rf_rsp1_valid_full", intf.rsp1_valid, 1'b1);
    chk("rf_rsp1_result_full", intf.rsp1_result, 32'd3);
    reset = 1'b1;
    intf.req0_valid = 1'b1; intf.req1_valid = 1'b1;
    @(negedge clk); #1;
    chk1("rf_rsp1_valid", intf.rsp1_valid, 1'b0);
    chk("rf_rsp1_result", intf.rsp1_result, 32'h0);
    chk1("rf_in_rst_req0_ready", intf.req0_ready, 1'b0);
    reset = 1'b0; #1;
    chk1("rf_req0_ready", intf.req0_ready, 1'b1);
    chk1("rf_req1_ready_lo", intf.req1_ready, 1'b0);
    @(negedge clk);
    intf.req0_valid = 1'b0; intf.req1_valid = 1'b0;
    intf.rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
